mfcc_context_assembler: RTL

- Sits between the DCT stage and the keyword-spotting CNN input in the MFCC pipeline.
- Accepts MFCC coefficients serially and quantises each to ACTIV_BITS with rounding and saturation.
- Assembles each frame's coefficients into a frame vector and keeps a sliding window of the last NUM_FRAMES frames.
- Emits the window with a valid/ready handshake, one window every `stride` frames, with backpressure to the coefficient source.

---
 rtl/mfcc_context_assembler.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mfcc_context_assembler.sv
// Quantises serial MFCC coefficients, assembles frame vectors and keeps a sliding
// window of the newest NUM_FRAMES frames, emitted every `stride` frames via valid/ready.
module mfcc_context_assembler #(
  parameter int IN_WIDTH   = 32,
  parameter int ACTIV_BITS = 8,
  parameter int MAX_COEFFS = 40,
  parameter int NUM_FRAMES = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [IN_WIDTH-1:0]                    coef_in,
  input  logic                                   coef_valid,
  output logic                                   coef_ready,
  input  logic [7:0]                             num_coeffs,
  input  logic [4:0]                             quant_shift,
  input  logic [3:0]                             stride,
  input  logic                                   flush,
  output logic [NUM_FRAMES*MAX_COEFFS*ACTIV_BITS-1:0] win_data,
  output logic                                   win_valid,
  input  logic                                   win_ready,
  output logic [CNT_WIDTH-1:0]                   sat_count
);

  localparam int F   = MAX_COEFFS * ACTIV_BITS;
  localparam int W   = NUM_FRAMES * F;
  localparam int FSW = $clog2(NUM_FRAMES + 1);
  localparam logic [7:0]     MAX_NC    = 8'(MAX_COEFFS);
  localparam logic [FSW-1:0] FULL      = FSW'(NUM_FRAMES);
  localparam logic [FSW-1:0] LAST_FILL = FSW'(NUM_FRAMES - 1);
  localparam logic signed [IN_WIDTH:0] Q_MAX = (IN_WIDTH+1)'(2**(ACTIV_BITS-1) - 1);
  localparam logic signed [IN_WIDTH:0] Q_MIN = -(IN_WIDTH+1)'(2**(ACTIV_BITS-1));

  typedef enum logic {FILL, STREAM} state_t;

  state_t               state;
  logic [7:0]           idx;
  logic [7:0]           nc_q;
  logic [FSW-1:0]       frames_seen;
  logic [3:0]           stride_cnt;
  logic [F-1:0]         staging;
  logic [W-1:0]         history;

  logic [7:0]           nc_in, nc_eff;
  logic [3:0]           stride_eff;
  logic                 last, fills_now, emit_frame, xfer, complete;
  logic signed [IN_WIDTH:0] q_ext, q_rnd, q_sum, q_shr;
  logic [ACTIV_BITS-1:0] q_val;
  logic                 clip;
  logic [F-1:0]         staging_next;
  logic [W-1:0]         history_next;

  assign nc_in      = (num_coeffs == 8'd0 || num_coeffs > MAX_NC) ? MAX_NC : num_coeffs;
  assign nc_eff     = (idx == 8'd0) ? nc_in : nc_q;
  assign last       = (idx == nc_eff - 8'd1);
  assign stride_eff = (stride == 4'd0) ? 4'd1 : stride;
  assign fills_now  = (frames_seen == LAST_FILL);
  assign emit_frame = fills_now || (state == STREAM && stride_cnt == stride_eff - 4'd1);
  // Only the last coefficient of an emitting frame can stall, and only on a pending window.
  assign coef_ready = !flush && !(win_valid && last && emit_frame);
  assign xfer       = coef_valid && coef_ready;
  assign complete   = xfer && last;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    q_ext = {coef_in[IN_WIDTH-1], coef_in};
    q_rnd = '0;
    if (quant_shift != 5'd0) q_rnd = (IN_WIDTH+1)'(1) << (quant_shift - 5'd1);
    q_sum = q_ext + q_rnd;
    q_shr = q_sum >>> quant_shift;
    clip  = 1'b1;
    if (q_shr > Q_MAX)      q_val = Q_MAX[ACTIV_BITS-1:0];
    else if (q_shr < Q_MIN) q_val = Q_MIN[ACTIV_BITS-1:0];
    else begin
      q_val = q_shr[ACTIV_BITS-1:0];
      clip  = 1'b0;
    end
  end

  always_comb begin
    staging_next = (idx == 8'd0) ? '0 : staging;
    for (int j = 0; j < MAX_COEFFS; j++)
      if (idx == 8'(j)) staging_next[j*ACTIV_BITS +: ACTIV_BITS] = q_val;
    history_next = {staging_next, history[W-1:F]};
  end

  // win_data is a capture of history so it stays put while non-emitting frames shift in.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FILL;
      idx         <= '0;
      nc_q        <= MAX_NC;
      frames_seen <= '0;
      stride_cnt  <= '0;
      staging     <= '0;
      history     <= '0;
      win_data    <= '0;
      win_valid   <= 1'b0;
      sat_count   <= '0;
    end else if (flush) begin
      state       <= FILL;
      idx         <= '0;
      frames_seen <= '0;
      stride_cnt  <= '0;
      staging     <= '0;
      history     <= '0;
      win_data    <= '0;
      win_valid   <= 1'b0;
    end else begin
      if (xfer) begin
        staging <= staging_next;
        if (idx == 8'd0) nc_q <= nc_in;
        idx <= complete ? 8'd0 : idx + 8'd1;
        if (clip && sat_count != '1) sat_count <= sat_count + CNT_WIDTH'(1);
      end
      if (win_valid && win_ready) win_valid <= 1'b0;
      if (complete) begin
        history <= history_next;
        if (frames_seen != FULL) frames_seen <= frames_seen + FSW'(1);
        if (fills_now) begin
          state      <= STREAM;
          stride_cnt <= '0;
          win_valid  <= 1'b1;
          win_data   <= history_next;
        end else if (state == STREAM) begin
          if (stride_cnt == stride_eff - 4'd1) begin
            stride_cnt <= '0;
            win_valid  <= 1'b1;
            win_data   <= history_next;
          end else begin
            stride_cnt <= stride_cnt + 4'd1;
          end
        end
      end
    end
  end

endmodule
